fp_to_int_seq: RTL and testbench
================================

Name: fp_to_int_seq

Overview:
- Sequential converter from IEEE-754 single precision to signed 32-bit two's-complement integer.
- Inverse path of the integer-to-float block.
- Sits between the FP datapath and integer consumers. Uses a valid/ready handshake on both sides.
- Alignment is iterative (bounded shift per cycle), so the block stays small and variable-latency.

Parameters:
- SHIFT_STEP, 4: max bit positions shifted per ALIGN cycle; legal 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- in_valid  in  1  input float presented.
- in_ready  out  1  block can accept; high only in IDLE.
- in_fp  in  32  {sign, exp[7:0], frac[22:0]}.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_int  out  32  signed result.
- out_invalid  out  1  input was NaN or Inf.
- out_overflow  out  1  finite value outside int32 range; result saturated.
- out_inexact  out  1  nonzero fraction bits discarded.

Behaviour:
- Reset values:
  - state = IDLE.
  - out_valid, out_int, and all flags = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation aborts the conversion; no result is emitted.
- States: IDLE -> ALIGN -> PACK -> DONE -> IDLE.
- IDLE:
  - in_valid && in_ready captures in_fp.
  - Decode: E = exp-127; mantissa m = {1,frac}.
  - Specials (exp==0, exp==255, E>=31, E<0) go straight to PACK.
  - Otherwise compute the shift and go to ALIGN; if the shift amount is 0, go to PACK.
- Shift amount:
  - E>23: left shift by E-23 (max 7).
  - E<23: right shift by 23-E (max 23).
- ALIGN:
  - Shift the working register by min(remaining, SHIFT_STEP) per cycle.
  - Right shifts OR the lost bits into a sticky bit and keep a guard bit.
  - Exit to PACK when remaining == 0.
  - ALIGN cycles = ceil(shamt/SHIFT_STEP).
- PACK (1 cycle): select value, negate if sign, apply saturation.
- DONE: out_valid=1, outputs stable; on out_ready go to IDLE.
- Latency from the accept edge to out_valid = ALIGN cycles + 2.
- New input is accepted no earlier than the cycle after the handshake completes.
- Specials and boundaries:
  - exp==0 (zero/denormal): 0; inexact = (frac!=0).
  - NaN: 0x7FFFFFFF, invalid.
  - +Inf: 0x7FFFFFFF, invalid.
  - -Inf: 0x80000000, invalid.
  - E>=31, positive: 0x7FFFFFFF, overflow.
  - E>=31, negative: 0x80000000. Overflow unless input == 0xCF000000 (exactly -2^31, no flags).
  - 0<=E<31: truncate toward zero; inexact = guard|sticky.
  - E<0 nonzero: 0, inexact.
  - Negative results: two's complement of the magnitude. -0.0 gives 0.
- Flags are mutually exclusive. Invalid/overflow suppress inexact.

Optional Feature:
- Macro FP2INT_ROUND_EN.
- Defined:
  - Round-to-nearest-even replaces truncation, using guard, sticky, and result LSB.
  - E==-1 can round to ±1.
  - A round-up that carries past 2^31-1 (positive) saturates with overflow.
  - Inexact is unchanged.
  - PACK becomes 2 cycles (round, then negate/saturate), so latency = ALIGN cycles + 3.
- Undefined: truncation toward zero, timing as above.

Decomposition:
- Shared package fp_pkg:
  - EXP_W=8, FRAC_W=23, BIAS=127.
  - INT32_MAX/INT32_MIN constants.
  - Field-slice helpers.
  - State enum {IDLE, ALIGN, PACK, DONE}.
  - Flag struct.
- One natural sub-module, fp_classify: combinational.
  - Inputs: the 32-bit float.
  - Outputs: is_zero, is_nan, is_inf, unbiased E, initial shift amount and direction.
  - Reusable by the integer-to-float side for checking.

Test Plan:
- 0x4B000000 (8388608.0), out_ready=1 -> out_int 0x00800000, no flags, out_valid 2 cycles after accept.
- 0x40490FDB (3.14159) -> 3, inexact, 6 ALIGN cycles, out_valid 8 cycles after accept. 0xC0490FDB -> 0xFFFFFFFD, inexact.
- 0xCF000000 -> 0x80000000, no flags. 0x4F000000 -> 0x7FFFFFFF, overflow. 0x7FC00000 -> 0x7FFFFFFF, invalid. 0xFF800000 -> 0x80000000, invalid.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: out_int/flags stable, in_ready=0.
  - Then out_ready=1: one transfer, then in_ready=1.
  - Assert rst during ALIGN: out_valid stays 0, state IDLE next cycle.
- 0x3F000000 (0.5) and 0x00000001 (denormal) -> 0, inexact. 0x80000000 (-0.0) -> 0, no flags.
- Rounding, with FP2INT_ROUND_EN:
  - 0x3FC00000 (1.5) -> 2.
  - 0x40200000 (2.5) -> 2.
  - 0xBFC00000 -> 0xFFFFFFFE.
  - Without the macro, 1.5 -> 1.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  fp_pkg
//  Shared single-precision field constants, helpers and types.
//  Revision: 1.0
// ============================================================================
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] INT32_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN   = 32'h8000_0000;
    localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        PACK  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_NUM = 2'd0,
        CLS_NAN = 2'd1,
        CLS_INF = 2'd2,
        CLS_BIG = 2'd3
    } cls_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } flags_t;

    function automatic logic fp_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [FRAC_W-1:0] fp_frac(input logic [31:0] f);
        return f[22:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  fp_classify
//  Combinational decode of a float: specials, unbiased exponent, align shift.
//  Revision: 1.0
// ============================================================================
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]       fp,
    output logic              sign,
    output logic              is_zero,
    output logic              is_nan,
    output logic              is_inf,
    output logic signed [9:0] e,
    output logic [4:0]        shamt,
    output logic              shift_left
);

    localparam logic signed [9:0] c_BIAS = 10'(BIAS);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;

    assign w_exp   = fp_exp(fp);
    assign w_frac  = fp_frac(fp);
    assign sign    = fp_sign(fp);
    assign is_zero = (w_exp == '0);
    assign is_nan  = (w_exp == '1) && (w_frac != '0);
    assign is_inf  = (w_exp == '1) && (w_frac == '0);
    assign e       = $signed({2'b00, w_exp}) - c_BIAS;

    // Shift is only meaningful for 0 <= e <= 30; other ranges report zero.
    always_comb begin
        shamt      = '0;
        shift_left = 1'b0;
        if ((e > 10'sd23) && (e < 10'sd31)) begin
            shift_left = 1'b1;
            shamt      = 5'(e - 10'sd23);
        end else if ((e >= 10'sd0) && (e < 10'sd23)) begin
            shamt      = 5'(10'sd23 - e);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_to_int_seq.sv
`default_nettype none
// ============================================================================
//  fp_to_int_seq
//  Iterative float32 -> int32 converter; FP2INT_ROUND_EN selects RNE rounding.
//  Revision: 1.0
// ============================================================================
module fp_to_int_seq
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        out_invalid,
    output logic        out_overflow,
    output logic        out_inexact
);

    localparam logic [4:0] c_STEP = 5'(SHIFT_STEP);

    logic              w_sign, w_is_zero, w_is_nan, w_is_inf, w_shl;
    logic signed [9:0] w_e;
    logic [4:0]        w_shamt;

    fp_classify u_classify (
        .fp         (in_fp),
        .sign       (w_sign),
        .is_zero    (w_is_zero),
        .is_nan     (w_is_nan),
        .is_inf     (w_is_inf),
        .e          (w_e),
        .shamt      (w_shamt),
        .shift_left (w_shl)
    );

    state_t      r_state, w_next;
    cls_t        r_cls;
    logic        r_sign, r_exact_min, r_left, r_guard, r_sticky;
    logic [31:0] r_mag;
    logic [4:0]  r_rem, w_step;
    logic [63:0] w_ext;
    logic        w_special, w_accept, w_pack_last;
    logic [32:0] w_mag_fin;
    logic [31:0] w_res_int, r_out_int;
    flags_t      w_res_flags, r_out_flags;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_special = w_is_zero || w_is_nan || w_is_inf ||
                       (w_e >= 10'sd31) || (w_e < 10'sd0);
    assign w_step    = (r_rem < c_STEP) ? r_rem : c_STEP;
    assign w_ext     = {r_mag, 32'h0} >> w_step;

`ifdef FP2INT_ROUND_EN
    logic        r_pack_ph;
    logic [32:0] r_rmag;
    logic        w_up;

    // Round to nearest, ties to the even integer.
    assign w_up        = r_guard && (r_sticky || r_mag[0]);
    assign w_pack_last = r_pack_ph;
    assign w_mag_fin   = r_rmag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_ph <= 1'b0;
            r_rmag    <= '0;
        end else if (r_state == PACK) begin
            r_pack_ph <= ~r_pack_ph;
            if (!r_pack_ph) begin
                r_rmag <= {1'b0, r_mag} + 33'(w_up);
            end
        end else begin
            r_pack_ph <= 1'b0;
        end
    end
`else
    assign w_pack_last = 1'b1;
    assign w_mag_fin   = {1'b0, r_mag};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = (w_special || (w_shamt == '0)) ? PACK : ALIGN;
                end
            end
            ALIGN:   if (r_rem == w_step) w_next = PACK;
            PACK:    if (w_pack_last)     w_next = DONE;
            DONE:    if (out_ready)       w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Zero and |x| < 1 are folded into the numeric path via guard/sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls       <= CLS_NUM;
            r_sign      <= 1'b0;
            r_exact_min <= 1'b0;
            r_left      <= 1'b0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_mag       <= '0;
            r_rem       <= '0;
        end else if (w_accept) begin
            r_sign      <= w_sign;
            r_exact_min <= (in_fp == FP_NEG_2P31);
            r_left      <= w_shl;
            r_rem       <= w_shamt;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_mag       <= {8'h00, 1'b1, fp_frac(in_fp)};
            r_cls       <= CLS_NUM;
            if (w_is_nan) begin
                r_cls <= CLS_NAN;
            end else if (w_is_inf) begin
                r_cls <= CLS_INF;
            end else if (w_is_zero) begin
                r_mag    <= '0;
                r_sticky <= (fp_frac(in_fp) != '0);
            end else if (w_e >= 10'sd31) begin
                r_cls <= CLS_BIG;
            end else if (w_e < 10'sd0) begin
                r_mag    <= '0;
                r_guard  <= (w_e == -10'sd1);
                r_sticky <= (w_e != -10'sd1) || (fp_frac(in_fp) != '0);
            end
        end else if (r_state == ALIGN) begin
            r_rem <= r_rem - w_step;
            if (r_left) begin
                r_mag <= r_mag << w_step;
            end else begin
                r_mag    <= w_ext[63:32];
                r_guard  <= w_ext[31];
                r_sticky <= r_sticky || r_guard || (w_ext[30:0] != '0);
            end
        end
    end

    always_comb begin
        w_res_int   = '0;
        w_res_flags = '0;
        case (r_cls)
            CLS_NAN: begin
                w_res_int           = INT32_MAX;
                w_res_flags.invalid = 1'b1;
            end
            CLS_INF: begin
                w_res_int           = r_sign ? INT32_MIN : INT32_MAX;
                w_res_flags.invalid = 1'b1;
            end
            CLS_BIG: begin
                w_res_int            = r_sign ? INT32_MIN : INT32_MAX;
                w_res_flags.overflow = !r_exact_min;
            end
            default: begin
                if (!r_sign && (w_mag_fin > {1'b0, INT32_MAX})) begin
                    w_res_int            = INT32_MAX;
                    w_res_flags.overflow = 1'b1;
                end else if (r_sign && (w_mag_fin > {1'b0, INT32_MIN})) begin
                    w_res_int            = INT32_MIN;
                    w_res_flags.overflow = 1'b1;
                end else begin
                    w_res_int           = r_sign ? (~w_mag_fin[31:0] + 32'd1) : w_mag_fin[31:0];
                    w_res_flags.inexact = r_guard || r_sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_int   <= '0;
            r_out_flags <= '0;
        end else if ((r_state == PACK) && w_pack_last) begin
            r_out_int   <= w_res_int;
            r_out_flags <= w_res_flags;
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign out_int      = r_out_int;
    assign out_invalid  = r_out_flags.invalid;
    assign out_overflow = r_out_flags.overflow;
    assign out_inexact  = r_out_flags.inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_seq.sv
`default_nettype none
// ============================================================================
//  tb_fp_to_int_seq
//  Directed-vector bench for fp_to_int_seq with hand-computed expectations.
//  Revision: 1.0
// ============================================================================
module tb_fp_to_int_seq;

`ifdef FP2INT_ROUND_EN
    localparam int c_EXTRA = 1;
`else
    localparam int c_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_fp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_int;
    logic        out_invalid, out_overflow, out_inexact;

    int n_checks = 0;
    int n_errors = 0;

    fp_to_int_seq #(.SHIFT_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_fp        (in_fp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_int      (out_int),
        .out_invalid  (out_invalid),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // flags packed as {invalid, overflow, inexact}; lat counts the accept edge as 1
    typedef struct {
        logic [31:0] fp;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    task automatic send(input logic [31:0] fp, input logic rdy, output int lat);
        @(negedge clk);
        in_fp     = fp;
        in_valid  = 1'b1;
        out_ready = rdy;
        check("in_ready_pre", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        send(v.fp, 1'b1, lat);
        check($sformatf("lat_%h", v.fp), 32'(lat), 32'(v.lat));
        check($sformatf("int_%h", v.fp), out_int, v.res);
        check($sformatf("flg_%h", v.fp), 32'({out_invalid, out_overflow, out_inexact}), 32'(v.flg));
        @(posedge clk);
        #1;
        check($sformatf("drop_%h", v.fp), 32'({out_valid, in_ready}), 32'b01);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int seen;
        logic [31:0] held_int;
        logic [2:0]  held_flg;

        vecs.push_back('{32'h4B000000, 32'h00800000, 3'b000, 2 + c_EXTRA});
        vecs.push_back('{32'h40490FDB, 32'h00000003, 3'b001, 8 + c_EXTRA});
        vecs.push_back('{32'hC0490FDB, 32'hFFFFFFFD, 3'b001, 8 + c_EXTRA});
        vecs.push_back('{32'hCF000000, 32'h80000000, 3'b000, 2 + c_EXTRA});
        vecs.push_back('{32'h4F000000, 32'h7FFFFFFF, 3'b010, 2 + c_EXTRA});
        vecs.push_back('{32'h7FC00000, 32'h7FFFFFFF, 3'b100, 2 + c_EXTRA});
        vecs.push_back('{32'h7F800000, 32'h7FFFFFFF, 3'b100, 2 + c_EXTRA});
        vecs.push_back('{32'hFF800000, 32'h80000000, 3'b100, 2 + c_EXTRA});
        vecs.push_back('{32'hCF800000, 32'h80000000, 3'b010, 2 + c_EXTRA});
        vecs.push_back('{32'h3F000000, 32'h00000000, 3'b001, 2 + c_EXTRA});
        vecs.push_back('{32'h00000001, 32'h00000000, 3'b001, 2 + c_EXTRA});
        vecs.push_back('{32'h80000000, 32'h00000000, 3'b000, 2 + c_EXTRA});
        vecs.push_back('{32'h3F800000, 32'h00000001, 3'b000, 8 + c_EXTRA});
        vecs.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 4 + c_EXTRA});
        vecs.push_back('{32'hCEFFFFFF, 32'h80000080, 3'b000, 4 + c_EXTRA});
        vecs.push_back('{32'h40200000, 32'h00000002, 3'b001, 8 + c_EXTRA});
`ifdef FP2INT_ROUND_EN
        vecs.push_back('{32'h3FC00000, 32'h00000002, 3'b001, 9});
        vecs.push_back('{32'hBFC00000, 32'hFFFFFFFE, 3'b001, 9});
        vecs.push_back('{32'h3F400000, 32'h00000001, 3'b001, 3});
`else
        vecs.push_back('{32'h3FC00000, 32'h00000001, 3'b001, 8});
        vecs.push_back('{32'hBFC00000, 32'hFFFFFFFF, 3'b001, 8});
        vecs.push_back('{32'h3F400000, 32'h00000000, 3'b001, 2});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {out_int[28:0], out_valid, out_invalid | out_overflow, out_inexact}, 32'd0);
        check("rst_int", out_int, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held while out_ready is low
        send(32'h40490FDB, 1'b0, lat);
        check("bp_lat", 32'(lat), 32'(8 + c_EXTRA));
        held_int = out_int;
        held_flg = {out_invalid, out_overflow, out_inexact};
        check("bp_int", held_int, 32'h00000003);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_int", out_int, 32'h00000003);
            check("bp_hold_ctl", 32'({out_valid, in_ready, out_invalid, out_overflow, out_inexact}), 32'b10001);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_release", 32'({out_valid, in_ready}), 32'b01);

        // Reset in the middle of ALIGN aborts the conversion
        send(32'h40490FDB, 1'b1, lat);
        check("pre_abort_done", 32'(lat), 32'(8 + c_EXTRA));
        @(posedge clk);
        @(negedge clk);
        in_fp    = 32'h40490FDB;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("abort_state", 32'({out_valid, in_ready}), 32'b01);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
